// File: rtl/seq_detector_param_if.sv
//------------------------------------------------------------------------------
// Module : seq_detector_param_if
// Brief  : Control/data/status bundle for the parametrised serial pattern
//          detector. The mask_in signal exists only with SEQ_DET_MASK_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_bit;
  logic             load;
  logic [PAT_W-1:0] pattern_in;
`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_in;
`endif
  logic             overlap;
  logic             clr_count;
  logic             flag;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             armed;

  modport master (
    output in_valid, in_bit, load, pattern_in, overlap, clr_count,
`ifdef SEQ_DET_MASK_EN
    output mask_in,
`endif
    input  flag, match_count, count_sat, armed
  );

  modport slave (
    input  in_valid, in_bit, load, pattern_in, overlap, clr_count,
`ifdef SEQ_DET_MASK_EN
    input  mask_in,
`endif
    output flag, match_count, count_sat, armed
  );
endinterface

`default_nettype wire

// File: rtl/seq_detector_param.sv
//------------------------------------------------------------------------------
// Module : seq_detector_param
// Brief  : Serial pattern detector, runtime-loadable PAT_W-bit pattern (MSB
//          first), overlap mode, registered match pulse, saturating counter.
//          Optional don't-care mask when SEQ_DET_MASK_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  wire logic           clock,
  input  wire logic           reset,
  seq_detector_param_if.slave bus
);

  localparam int               c_FW       = $clog2(PAT_W);
  localparam logic [c_FW-1:0]  c_FILL_MAX = c_FW'(PAT_W - 1);
  localparam logic [c_FW-1:0]  c_FILL_ONE = c_FW'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [PAT_W-1:0] r_pattern, w_pattern_nxt;
  logic [PAT_W-1:0] r_mask,    w_mask_nxt;
  logic [PAT_W-2:0] r_history, w_history_nxt;
  logic [c_FW-1:0]  r_fill,    w_fill_nxt;
  logic             r_flag,    w_flag_nxt;
  logic [CNT_W-1:0] r_count,   w_count_nxt;
  logic             r_sat,     w_sat_nxt;
  logic             r_armed,   w_armed_nxt;

  logic             w_accept;
  logic [PAT_W-1:0] w_window;
  logic [PAT_W-1:0] w_diff;
  logic             w_hit;

  assign w_accept = bus.in_valid & ~bus.load;
  assign w_window = {r_history, bus.in_bit};
  assign w_diff   = (w_window ^ r_pattern) & r_mask;
  assign w_hit    = w_accept && (r_fill == c_FILL_MAX) && (w_diff == '0);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pattern <= '0;
      r_mask    <= '1;
      r_history <= '0;
      r_fill    <= '0;
      r_flag    <= 1'b0;
      r_count   <= '0;
      r_sat     <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_pattern <= w_pattern_nxt;
      r_mask    <= w_mask_nxt;
      r_history <= w_history_nxt;
      r_fill    <= w_fill_nxt;
      r_flag    <= w_flag_nxt;
      r_count   <= w_count_nxt;
      r_sat     <= w_sat_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_pattern_nxt = r_pattern;
    w_mask_nxt    = r_mask;
    w_history_nxt = r_history;
    w_fill_nxt    = r_fill;
    w_flag_nxt    = 1'b0;
    w_count_nxt   = r_count;
    w_sat_nxt     = r_sat;

    if (bus.load) begin
      w_pattern_nxt = bus.pattern_in;
`ifdef SEQ_DET_MASK_EN
      w_mask_nxt    = bus.mask_in;
`endif
      w_history_nxt = '0;
      w_fill_nxt    = '0;
    end else if (bus.in_valid) begin
      w_history_nxt = w_window[PAT_W-2:0];
      w_flag_nxt    = w_hit;
      // Non-overlapping mode discards the history fill so the next match needs PAT_W fresh bits
      if (w_hit && !bus.overlap)
        w_fill_nxt = '0;
      else if (r_fill != c_FILL_MAX)
        w_fill_nxt = r_fill + c_FILL_ONE;
    end

    if (bus.clr_count) begin
      w_count_nxt = '0;
      w_sat_nxt   = 1'b0;
    end else if (w_hit && (r_count != c_CNT_MAX)) begin
      w_count_nxt = r_count + c_CNT_ONE;
      if (w_count_nxt == c_CNT_MAX)
        w_sat_nxt = 1'b1;
    end

    w_armed_nxt = (w_fill_nxt == c_FILL_MAX);
  end

  // Outputs
  assign bus.flag        = r_flag;
  assign bus.match_count = r_count;
  assign bus.count_sat   = r_sat;
  assign bus.armed       = r_armed;

endmodule

`default_nettype wire
